minisys_muldiv: RTL and testbench
=================================

# minisys_muldiv

Parametrised iterative multiply/divide unit for the Minisys EXE stage, owning the HI/LO register pair. It executes MULT, MULTU, DIV, DIVU, MTHI and MTLO over configurable operand width, one bit per cycle. It reports busy to the pipeline hazard logic, can be cancelled by an exception flush, and flags divide-by-zero. It supersedes the fixed-width mult/div path inside the execute stage.

## Interface
- WIDTH, 32, operand and HI/LO width; must be ≥4 and even
- CNT_W, $clog2(WIDTH)+1, iteration counter width (derived, not overridden)
- clk  in  1  single clock; all state updates on rising edge
- rst  in  1  reset; synchronous and active-high
- start  in  1  operation request, sampled only in IDLE
- op  in  3  0 none, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MTHI, 6 MTLO, 7 reserved (treated as none)
- srca  in  WIDTH  multiplicand / dividend / MTHI-MTLO data
- srcb  in  WIDTH  multiplier / divisor
- cancel  in  1  flush; aborts an operation in flight
- busy  out  1  state ≠ IDLE (combinational from state)
- done  out  1  one-cycle pulse, the cycle HI/LO are written
- divzero  out  1  pulses with done when a DIV/DIVU had srcb = 0
- hi, lo  out  WIDTH  architectural HI/LO registers

## Operation
- States: IDLE, RUN, FIX.
- IDLE + start + op∈{1..4} + !cancel: latch operand magnitudes (signed ops: two's-complement absolute value into WIDTH-bit unsigned), result signs, divzero flag; counter←WIDTH; go RUN.
- IDLE + start + op=5/6 + !cancel: hi (or lo) ← srca at that edge; stay IDLE; no done.
- RUN: one shift-add (multiply) or restoring shift-subtract (divide) step per cycle; counter decrements; at counter=1 go FIX.
- FIX: apply sign correction, write {hi,lo}, assert done (and divzero if flagged), go IDLE.
- Multiply: {hi,lo} = 2·WIDTH-bit product, signed for MULT, unsigned for MULTU.
- Divide: lo = quotient, hi = remainder; signed truncates toward zero, remainder takes dividend sign; MIN/−1 gives lo=MIN, hi=0.
- Divide by zero: full latency, hi/lo unchanged, divzero=1 with done.
- start while busy: ignored (pipeline must stall on busy); no queuing.
- cancel in RUN or FIX: next state IDLE, hi/lo unchanged, no done. cancel in IDLE suppresses a same-cycle start, including MTHI/MTLO.
- rst: dominates everything, including mid-operation.

## Timing
- Reset values: state IDLE, hi=0, lo=0, busy=0, done=0, divzero=0, counter=0.
- start accepted at edge T: busy=1 in cycles T+1 … T+WIDTH+1; done/divzero high in cycle T+WIDTH+1 only; new hi/lo visible from T+WIDTH+2, when busy=0.
- Back-to-back: a new start may be presented in the cycle busy drops (T+WIDTH+2).
- MTHI/MTLO: value visible in the cycle after the start edge; busy never rises.
- done and cancel in the same FIX cycle: cancel wins (no write, done=0).

## Structure
- Shared package minisys_pkg: op encoding localparams (MD_NONE…MD_MTLO), state typedef md_state_t.
- One sub-module natural: minisys_md_datapath (iteration accumulator, shift/add/subtract step, FIX-stage negation); FSM, counter and HI/LO registers stay in minisys_muldiv.

## Test plan
- WIDTH=32, MULT srca=0xFFFFFFFD (−3), srcb=7 -> done at start+33, hi=0xFFFFFFFF, lo=0xFFFFFFEB; busy high exactly 33 cycles.
- WIDTH=32, DIV srca=−7, srcb=2 -> lo=0xFFFFFFFD (−3), hi=0xFFFFFFFF (−1); DIVU 7/2 -> lo=3, hi=1.
- WIDTH=32, DIV srca=0x80000000, srcb=0xFFFFFFFF -> lo=0x80000000, hi=0; DIVU x/0 -> divzero=1 with done, hi/lo unchanged.
- MTHI 0x1234 then MTLO 0x5678 on consecutive cycles -> hi=0x1234, lo=0x5678 next cycles, busy stays 0; MTHI during busy -> ignored.
- MULTU started, cancel at start+10 -> IDLE next cycle, no done, hi/lo retain prior values; rst asserted mid-DIV -> all outputs to reset values next edge.
- WIDTH=8, MULTU 0xFF×0xFF -> hi=0xFE, lo=0x01, done at start+9; random signed/unsigned sweep vs reference model at WIDTH=8 and 32.

Source files
------------

// File: rtl/minisys_pkg.sv
// Shared definitions for the Minisys multiply/divide unit.
// Op encodings, FSM state type and op classification helper.
package minisys_pkg;

   localparam logic [2:0] MD_NONE  = 3'd0;
   localparam logic [2:0] MD_MULT  = 3'd1;
   localparam logic [2:0] MD_MULTU = 3'd2;
   localparam logic [2:0] MD_DIV   = 3'd3;
   localparam logic [2:0] MD_DIVU  = 3'd4;
   localparam logic [2:0] MD_MTHI  = 3'd5;
   localparam logic [2:0] MD_MTLO  = 3'd6;

   typedef enum logic [1:0] {
      MD_IDLE,
      MD_RUN,
      MD_FIX
   } md_state_t;

   function automatic logic md_is_arith(input logic [2:0] op);
      return (op == MD_MULT) || (op == MD_MULTU) ||
             (op == MD_DIV)  || (op == MD_DIVU);
   endfunction

endpackage

// File: rtl/minisys_md_datapath.sv
// Iterative mul/div datapath: one shift-add or restoring
// shift-subtract step per cycle, sign fix-up on the result.
module minisys_md_datapath
   import minisys_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load,
   input  logic             step,
   input  logic [2:0]       op,
   input  logic [WIDTH-1:0] srca,
   input  logic [WIDTH-1:0] srcb,
   output logic             dz,
   output logic [WIDTH-1:0] res_hi,
   output logic [WIDTH-1:0] res_lo
);

   logic [WIDTH-1:0]   acc_hi;
   logic [WIDTH-1:0]   acc_lo;
   logic [WIDTH-1:0]   mag_b;
   logic               is_div;
   logic               neg_lo;
   logic               neg_hi;
   logic               op_div;
   logic               op_sgn;
   logic               sa;
   logic               sb;
   logic [WIDTH:0]     sum;
   logic [WIDTH:0]     shl;
   logic [WIDTH:0]     diff;
   logic [2*WIDTH-1:0] prod;
   logic [2*WIDTH-1:0] prod_n;

   assign op_div = (op == MD_DIV) || (op == MD_DIVU);
   assign op_sgn = (op == MD_MULT) || (op == MD_DIV);
   assign sa     = op_sgn & srca[WIDTH-1];
   assign sb     = op_sgn & srcb[WIDTH-1];

   // multiply: acc_hi accumulates, acc_lo holds the multiplier
   assign sum  = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, mag_b} : '0);
   // divide: acc_hi is the partial remainder, acc_lo the dividend/quotient
   assign shl  = {acc_hi, acc_lo[WIDTH-1]};
   assign diff = shl - {1'b0, mag_b};

   assign prod   = {acc_hi, acc_lo};
   assign prod_n = neg_lo ? -prod : prod;

   // Operand capture on load, one iteration per step
   always_ff @(posedge clk) begin
      if (rst) begin
         acc_hi <= '0;
         acc_lo <= '0;
         mag_b  <= '0;
         is_div <= 1'b0;
         neg_lo <= 1'b0;
         neg_hi <= 1'b0;
         dz     <= 1'b0;
      end else if (load) begin
         acc_hi <= '0;
         acc_lo <= sa ? -srca : srca;
         mag_b  <= sb ? -srcb : srcb;
         is_div <= op_div;
         neg_lo <= sa ^ sb;
         neg_hi <= sa;
         dz     <= op_div && (srcb == '0);
      end else if (step) begin
         if (is_div) begin
            acc_hi <= diff[WIDTH] ? shl[WIDTH-1:0] : diff[WIDTH-1:0];
            acc_lo <= {acc_lo[WIDTH-2:0], ~diff[WIDTH]};
         end else begin
            acc_hi <= sum[WIDTH:1];
            acc_lo <= {sum[0], acc_lo[WIDTH-1:1]};
         end
      end
   end

   // Sign correction of the finished magnitudes
   always_comb begin
      res_hi = '0;
      res_lo = '0;
      if (is_div) begin
         res_hi = neg_hi ? -acc_hi : acc_hi;
         res_lo = neg_lo ? -acc_lo : acc_lo;
      end else begin
         res_hi = prod_n[2*WIDTH-1:WIDTH];
         res_lo = prod_n[WIDTH-1:0];
      end
   end

endmodule

// File: rtl/minisys_muldiv.sv
// Minisys EXE-stage multiply/divide unit owning HI/LO.
// FSM, iteration counter and architectural HI/LO live here.
module minisys_muldiv
   import minisys_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [2:0]       op,
   input  logic [WIDTH-1:0] srca,
   input  logic [WIDTH-1:0] srcb,
   input  logic             cancel,
   output logic             busy,
   output logic             done,
   output logic             divzero,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);

   localparam int CNT_W = $clog2(WIDTH) + 1;

   md_state_t        state;
   logic [CNT_W-1:0] cnt;
   logic             load;
   logic             dz;
   logic [WIDTH-1:0] res_hi;
   logic [WIDTH-1:0] res_lo;

   assign load    = (state == MD_IDLE) && start && !cancel &&
                    md_is_arith(op);
   assign busy    = (state != MD_IDLE);
   assign done    = (state == MD_FIX) && !cancel;
   assign divzero = done && dz;

   minisys_md_datapath #(
      .WIDTH (WIDTH)
   ) u_dp (
      .clk    (clk),
      .rst    (rst),
      .load   (load),
      .step   (state == MD_RUN),
      .op     (op),
      .srca   (srca),
      .srcb   (srcb),
      .dz     (dz),
      .res_hi (res_hi),
      .res_lo (res_lo)
   );

   // Control FSM with iteration count and HI/LO writeback
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= MD_IDLE;
         cnt   <= '0;
         hi    <= '0;
         lo    <= '0;
      end else begin
         unique case (state)
            MD_IDLE: begin
               if (load) begin
                  state <= MD_RUN;
                  cnt   <= CNT_W'(WIDTH);
               end else if (start && !cancel) begin
                  if (op == MD_MTHI) hi <= srca;
                  if (op == MD_MTLO) lo <= srca;
               end
            end
            MD_RUN: begin
               if (cancel) begin
                  state <= MD_IDLE;
                  cnt   <= '0;
               end else begin
                  cnt <= cnt - CNT_W'(1);
                  if (cnt == CNT_W'(1)) state <= MD_FIX;
               end
            end
            MD_FIX: begin
               state <= MD_IDLE;
               cnt   <= '0;
               if (done && !dz) begin
                  hi <= res_hi;
                  lo <= res_lo;
               end
            end
            default: begin
               state <= MD_IDLE;
               cnt   <= '0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_minisys_muldiv.sv
// Directed and model-checked bench for minisys_muldiv.
// Drives a WIDTH=32 and a WIDTH=8 instance.
module tb_minisys_muldiv;
   import minisys_pkg::*;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start32 = 1'b0;
   logic        start8 = 1'b0;
   logic [2:0]  op = MD_NONE;
   logic [31:0] srca = '0;
   logic [31:0] srcb = '0;
   logic        cancel = 1'b0;

   logic        busy32, done32, divzero32;
   logic [31:0] hi32, lo32;
   logic        busy8, done8, divzero8;
   logic [7:0]  hi8, lo8;

   int n_checks = 0;
   int n_errors = 0;

   logic [31:0] m_hi [2];
   logic [31:0] m_lo [2];

   always #5 clk = ~clk;

   minisys_muldiv #(.WIDTH(32)) dut32 (
      .clk     (clk),
      .rst     (rst),
      .start   (start32),
      .op      (op),
      .srca    (srca),
      .srcb    (srcb),
      .cancel  (cancel),
      .busy    (busy32),
      .done    (done32),
      .divzero (divzero32),
      .hi      (hi32),
      .lo      (lo32)
   );

   minisys_muldiv #(.WIDTH(8)) dut8 (
      .clk     (clk),
      .rst     (rst),
      .start   (start8),
      .op      (op),
      .srca    (srca[7:0]),
      .srcb    (srcb[7:0]),
      .cancel  (cancel),
      .busy    (busy8),
      .done    (done8),
      .divzero (divzero8),
      .hi      (hi8),
      .lo      (lo8)
   );

   task automatic check(input string tag, input logic [63:0] got,
                        input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic logic [63:0] ref_md(input bit w8,
      input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
      input logic [31:0] oh, input logic [31:0] ol);
      longint sa, sb, ua, ub, p, q, r;
      p = 0; q = 0; r = 0;
      if (w8) begin
         sa = longint'($signed(a[7:0]));
         sb = longint'($signed(b[7:0]));
         ua = longint'({56'b0, a[7:0]});
         ub = longint'({56'b0, b[7:0]});
      end else begin
         sa = longint'($signed(a));
         sb = longint'($signed(b));
         ua = longint'({32'b0, a});
         ub = longint'({32'b0, b});
      end
      if (o == MD_MULT || o == MD_MULTU) begin
         p = (o == MD_MULT) ? sa * sb : ua * ub;
         if (w8) return {24'b0, p[15:8], 24'b0, p[7:0]};
         return p;
      end
      if (o == MD_DIV) begin
         if (sb == 0) return {oh, ol};
         q = sa / sb;
         r = sa % sb;
      end else begin
         if (ub == 0) return {oh, ol};
         q = ua / ub;
         r = ua % ub;
      end
      if (w8) return {24'b0, r[7:0], 24'b0, q[7:0]};
      return {r[31:0], q[31:0]};
   endfunction

   // Caller is positioned just after a falling edge.
   task automatic run_md(input bit w8, input logic [2:0] o,
      input logic [31:0] a, input logic [31:0] b,
      input int cancel_at, input int mthi_at, input int rst_at,
      output int busy_n, output int done_at, output bit dz_seen);
      bit bz;
      op = o;
      srca = a;
      srcb = b;
      if (w8) start8 = 1'b1;
      else start32 = 1'b1;
      @(negedge clk);
      busy_n = 0;
      done_at = 0;
      dz_seen = 1'b0;
      bz = 1'b1;
      for (int k = 1; k <= 80 && bz; k++) begin
         start8 = 1'b0;
         start32 = 1'b0;
         op = MD_NONE;
         cancel = 1'b0;
         rst = 1'b0;
         if (k == cancel_at) cancel = 1'b1;
         if (k == rst_at) rst = 1'b1;
         if (k == mthi_at) begin
            if (w8) start8 = 1'b1;
            else start32 = 1'b1;
            op = MD_MTHI;
            srca = 32'h0000DEAD;
         end
         #1;
         bz = w8 ? busy8 : busy32;
         if (w8 ? done8 : done32) begin
            done_at = k;
            dz_seen = w8 ? divzero8 : divzero32;
         end
         if (bz) begin
            busy_n++;
            @(negedge clk);
         end
      end
      cancel = 1'b0;
      rst = 1'b0;
      if (bz) check("timeout", 1, 0);
   endtask

   task automatic op_check(input string tag, input bit w8,
      input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
      input logic [31:0] eh, input logic [31:0] el, input bit edz);
      int bn, da, w, idx;
      bit dz;
      w = w8 ? 8 : 32;
      idx = w8 ? 1 : 0;
      run_md(w8, o, a, b, 0, 0, 0, bn, da, dz);
      check({tag, ".done_at"}, da, w + 1);
      check({tag, ".busy_n"}, bn, w + 1);
      check({tag, ".dz"}, dz, edz);
      if (w8) check({tag, ".hilo"}, {24'b0, hi8, 24'b0, lo8}, {eh, el});
      else check({tag, ".hilo"}, {hi32, lo32}, {eh, el});
      m_hi[idx] = eh;
      m_lo[idx] = el;
   endtask

   initial begin
      int bn, da;
      bit dz, w8;
      logic [2:0] o;
      logic [31:0] a, b;
      logic [63:0] e;
      bit edz;

      m_hi[0] = '0; m_lo[0] = '0;
      m_hi[1] = '0; m_lo[1] = '0;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      #1;
      check("reset32", {busy32, done32, divzero32, hi32, lo32}, '0);
      check("reset8", {busy8, done8, divzero8, hi8, lo8}, '0);

      op_check("mult_neg", 0, MD_MULT, 32'hFFFFFFFD, 32'd7,
               32'hFFFFFFFF, 32'hFFFFFFEB, 0);
      op_check("div_neg", 0, MD_DIV, 32'hFFFFFFF9, 32'd2,
               32'hFFFFFFFF, 32'hFFFFFFFD, 0);
      op_check("divu", 0, MD_DIVU, 32'd7, 32'd2, 32'd1, 32'd3, 0);
      op_check("div_min", 0, MD_DIV, 32'h80000000, 32'hFFFFFFFF,
               32'h0, 32'h80000000, 0);
      op_check("divu_zero", 0, MD_DIVU, 32'h1234, 32'h0,
               32'h0, 32'h80000000, 1);

      start32 = 1'b1; op = MD_MTHI; srca = 32'h1234;
      @(negedge clk); #1;
      check("mthi.hi", hi32, 32'h1234);
      check("mthi.busy", {busy32, done32}, 2'b00);
      op = MD_MTLO; srca = 32'h5678;
      @(negedge clk); #1;
      check("mtlo.hilo", {hi32, lo32}, {32'h1234, 32'h5678});
      check("mtlo.busy", {busy32, done32}, 2'b00);
      start32 = 1'b0; op = MD_NONE;

      run_md(0, MD_MULTU, 32'd3, 32'd4, 0, 5, 0, bn, da, dz);
      check("mthi_busy.done_at", da, 33);
      check("mthi_busy.hilo", {hi32, lo32}, {32'h0, 32'd12});
      m_hi[0] = 32'h0; m_lo[0] = 32'd12;

      run_md(0, MD_MULTU, 32'hFFFF, 32'hFFFF, 10, 0, 0, bn, da, dz);
      check("cancel_run.busy_n", bn, 10);
      check("cancel_run.done", da, 0);
      check("cancel_run.hilo", {hi32, lo32}, {32'h0, 32'd12});

      run_md(0, MD_DIVU, 32'd100, 32'd9, 33, 0, 0, bn, da, dz);
      check("cancel_fix.busy_n", bn, 33);
      check("cancel_fix.done", da, 0);
      check("cancel_fix.hilo", {hi32, lo32}, {32'h0, 32'd12});

      start32 = 1'b1; op = MD_MTHI; srca = 32'hBEEF; cancel = 1'b1;
      @(negedge clk); #1;
      check("cancel_idle.mthi", hi32, 32'h0);
      op = MD_MULT;
      @(negedge clk); #1;
      check("cancel_idle.mult", busy32, 1'b0);
      start32 = 1'b0; op = MD_NONE; cancel = 1'b0;

      op_check("w8_ff", 1, MD_MULTU, 32'hFF, 32'hFF, 32'hFE, 32'h01, 0);

      for (int i = 0; i < 40; i++) begin
         w8 = (i < 22);
         o = 3'($urandom_range(1, 4));
         a = $urandom;
         b = $urandom;
         if ($urandom_range(0, 5) == 0) b = 32'h0;
         if ($urandom_range(0, 3) == 0) b = b & 32'h0000000F;
         e = ref_md(w8, o, a, b, m_hi[w8 ? 1 : 0], m_lo[w8 ? 1 : 0]);
         edz = (o == MD_DIV || o == MD_DIVU) &&
               (w8 ? (b[7:0] == 8'h0) : (b == 32'h0));
         op_check(w8 ? "rand8" : "rand32", w8, o, a, b,
                  e[63:32], e[31:0], edz);
      end

      op_check("pre_rst", 0, MD_MULTU, 32'h10001, 32'h30003,
               32'h3, 32'h00060003, 0);
      run_md(0, MD_DIV, 32'd100, 32'd7, 0, 0, 12, bn, da, dz);
      check("rst_mid.busy_n", bn, 12);
      check("rst_mid32", {busy32, done32, divzero32, hi32, lo32}, '0);
      check("rst_mid8", {busy8, done8, divzero8, hi8, lo8}, '0);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
